// File: rtl/rv32m_pkg.sv
// Shared RV32M definitions: operand width, funct3 encodings and the
// mul/div unit state encoding.
package rv32m_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_DIV  = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

endpackage

// File: rtl/mul_div_unit_div_step.sv
// One radix-2 restoring division iteration: shift the next dividend bit
// into the partial remainder, trial-subtract the divisor and keep the
// difference only when it does not go negative.
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_rem,
    input  logic [W-1:0] i_quo,
    input  logic [W-1:0] i_div,
    output logic [W-1:0] o_rem,
    output logic [W-1:0] o_quo
);

    // The shifted remainder needs one extra bit; the borrow out of that
    // extra bit tells whether the divisor fits.
    logic [W:0] w_shift;
    logic [W:0] w_diff;
    logic       w_fits;

    assign w_shift = {i_rem, i_quo[W-1]};
    assign w_diff  = w_shift - {1'b0, i_div};
    assign w_fits  = ~w_diff[W];

    // Restore or keep the trial difference and shift in the quotient bit
    always_comb begin
        o_rem = w_shift[W-1:0];
        if (w_fits) begin
            o_rem = w_diff[W-1:0];
        end
        o_quo = {i_quo[W-2:0], w_fits};
    end

endmodule

// File: rtl/mul_div_unit.sv
// RV32M execute unit: single-cycle multiplier plus a 32-iteration
// restoring divider. The dividend is held in the quotient register and
// shifted out one bit per iteration while quotient bits shift in.
module mul_div_unit
    import rv32m_pkg::*;
#(
    parameter int XLEN = rv32m_pkg::XLEN
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic            KILL,
    input  logic [2:0]      FUNCT3,
    input  logic [XLEN-1:0] DATA1,
    input  logic [XLEN-1:0] DATA2,
    output logic [XLEN-1:0] RESULT,
    output logic            BUSY,
    output logic            DONE
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [4:0]      LAST_CNT = 5'd31;

    function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] v);
        return neg ? -v : v;
    endfunction

    md_state_t       r_state;
    md_state_t       w_state_next;
    logic [4:0]      r_cnt;
    logic [XLEN-1:0] r_result;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_divisor;
    logic            r_is_rem;
    logic            r_q_neg;
    logic            r_r_neg;

    logic            w_accept;
    logic            w_is_div;
    logic            w_is_rem;
    logic            w_signed_div;
    logic            w_div_zero;
    logic            w_overflow;
    logic            w_special;
    logic            w_div_iter;
    logic [XLEN-1:0] w_special_res;

    logic                   w_a_signed;
    logic                   w_b_signed;
    logic signed [2*XLEN-1:0] w_mul_a;
    logic signed [2*XLEN-1:0] w_mul_b;
    logic signed [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]        w_mul_res;

    logic [XLEN-1:0] w_rem_next;
    logic [XLEN-1:0] w_quo_next;
    logic [XLEN-1:0] w_div_res;

    // START is honoured outside the divide loop and never alongside KILL
    assign w_accept     = START && !KILL && (r_state != MD_DIV);
    assign w_is_div     = FUNCT3[2];
    assign w_is_rem     = FUNCT3[1];
    assign w_signed_div = ~FUNCT3[0];
    assign w_div_zero   = (DATA2 == '0);
    assign w_overflow   = w_signed_div && (DATA1 == MIN_NEG) && (DATA2 == '1);
    assign w_special    = w_is_div && (w_div_zero || w_overflow);
    assign w_div_iter   = w_accept && w_is_div && !w_special;

    // Divide-by-zero wins over overflow; both resolve without iterating
    always_comb begin
        if (w_div_zero) begin
            w_special_res = w_is_rem ? DATA1 : '1;
        end else begin
            w_special_res = w_is_rem ? '0 : MIN_NEG;
        end
    end

    // Operands are sign- or zero-extended to full product width so a single
    // multiply covers all four signedness combinations.
    assign w_a_signed = (FUNCT3 == F3_MULH) || (FUNCT3 == F3_MULHSU);
    assign w_b_signed = (FUNCT3 == F3_MULH);
    assign w_mul_a    = {{XLEN{w_a_signed & DATA1[XLEN-1]}}, DATA1};
    assign w_mul_b    = {{XLEN{w_b_signed & DATA2[XLEN-1]}}, DATA2};
    assign w_prod     = w_mul_a * w_mul_b;
    assign w_mul_res  = (FUNCT3 == F3_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

    div_step #(
        .W (XLEN)
    ) u_div_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_div (r_divisor),
        .o_rem (w_rem_next),
        .o_quo (w_quo_next)
    );

    // Sign fix-up of the final iteration's output
    assign w_div_res = r_is_rem ? neg_if(r_r_neg, w_rem_next) : neg_if(r_q_neg, w_quo_next);

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= MD_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            MD_IDLE, MD_DONE: begin
                if (KILL) begin
                    w_state_next = MD_IDLE;
                end else if (w_accept) begin
                    w_state_next = w_div_iter ? MD_DIV : MD_DONE;
                end else begin
                    w_state_next = MD_IDLE;
                end
            end
            MD_DIV: begin
                if (KILL) begin
                    w_state_next = MD_IDLE;
                end else if (r_cnt == '0) begin
                    w_state_next = MD_DONE;
                end
            end
            default: w_state_next = MD_IDLE;
        endcase
    end

    // Status outputs decoded from the state
    always_comb begin
        BUSY = (r_state == MD_DIV);
        DONE = (r_state == MD_DONE);
    end

    // Iteration counter: loaded on divide launch, counts down to zero
    always_ff @(posedge CLK) begin
        if (RESET || KILL) begin
            r_cnt <= '0;
        end else if (w_div_iter) begin
            r_cnt <= LAST_CNT;
        end else if (r_state == MD_DIV && r_cnt != '0) begin
            r_cnt <= r_cnt - 5'd1;
        end
    end

    // Result register: multiply, special divide or final divide iteration
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_result <= '0;
        end else if (!KILL) begin
            if (w_accept && !w_is_div) begin
                r_result <= w_mul_res;
            end else if (w_accept && w_special) begin
                r_result <= w_special_res;
            end else if (r_state == MD_DIV && r_cnt == '0) begin
                r_result <= w_div_res;
            end
        end
    end

    // Divider datapath: capture magnitudes and sign flags, then iterate
    always_ff @(posedge CLK) begin
        if (w_div_iter) begin
            r_rem     <= '0;
            r_quo     <= neg_if(w_signed_div & DATA1[XLEN-1], DATA1);
            r_divisor <= neg_if(w_signed_div & DATA2[XLEN-1], DATA2);
            r_is_rem  <= w_is_rem;
            r_q_neg   <= w_signed_div & (DATA1[XLEN-1] ^ DATA2[XLEN-1]);
            r_r_neg   <= w_signed_div & DATA1[XLEN-1];
        end else if (r_state == MD_DIV) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
        end
    end

    assign RESULT = r_result;

endmodule
